// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle between the async FIFO read controller, its memory and the write domain.
// slave = controller side, master = consumer/memory/write-domain side.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_SIZE = 3,
  parameter int DATA_SIZE = 8
);
  logic                 rd_en;
  logic [ADDR_SIZE:0]   wptr_gray;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic [ADDR_SIZE-1:0] raddr;
  logic [ADDR_SIZE:0]   rptr_gray;
  logic [DATA_SIZE-1:0] rdata;
  logic                 rvalid;
  logic                 rempty;
  logic                 rd_underflow;
  logic                 ralmost_empty;

  modport slave (
    input  rd_en, wptr_gray, mem_rdata,
    output raddr, rptr_gray, rdata, rvalid, rempty, rd_underflow, ralmost_empty
  );

  modport master (
    output rd_en, wptr_gray, mem_rdata,
    input  raddr, rptr_gray, rdata, rvalid, rempty, rd_underflow, ralmost_empty
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read controller: 2-flop Gray sync of wptr, binary/Gray read pointer, empty flag, 1-cycle read data.
// Optional RD_ALMOST_EMPTY_EN builds a registered level-based almost-empty flag; otherwise it mirrors rempty.
module fifo_rd_ctrl #(
  parameter int ADDR_SIZE = 3,
  parameter int DATA_SIZE = 8,
  parameter int AE_LEVEL  = 2
) (
  input  logic           rclk,
  input  logic           rrst,
  fifo_rd_ctrl_if.slave  bus
);
  localparam int PTR_W = ADDR_SIZE + 1;

  if (AE_LEVEL < 0 || AE_LEVEL >= (2**PTR_W)) begin : g_ae_range
    $error("AE_LEVEL out of range for the pointer width");
  end

  logic [PTR_W-1:0]     r_wq1;
  logic [PTR_W-1:0]     r_wq2;
  logic [PTR_W-1:0]     r_rbin;
  logic [PTR_W-1:0]     r_rgray;
  logic [DATA_SIZE-1:0] r_rdata;
  logic                 r_rvalid;
  logic                 r_rempty;
  logic                 r_underflow;

  logic                 w_accept;
  logic [PTR_W-1:0]     w_rbin_next;
  logic [PTR_W-1:0]     w_rgray_next;

  assign w_accept     = bus.rd_en & ~r_rempty;
  assign w_rbin_next  = r_rbin + PTR_W'(w_accept);
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_wq1       <= '0;
      r_wq2       <= '0;
      r_rbin      <= '0;
      r_rgray     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_rempty    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_wq1    <= bus.wptr_gray;
      r_wq2    <= r_wq1;
      r_rbin   <= w_rbin_next;
      r_rgray  <= w_rgray_next;
      // Compare against the post-increment pointer so the last-word read flags empty on its own edge.
      r_rempty <= (w_rgray_next == r_wq2);
      r_rvalid <= w_accept;
      if (w_accept) begin
        r_rdata <= bus.mem_rdata;
      end
      if (bus.rd_en && r_rempty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  logic [PTR_W-1:0] w_wbin;
  logic [PTR_W-1:0] w_level;
  logic             r_ae;

  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < PTR_W; i++) begin
      w_wbin[i] = ^(r_wq2 >> i);
    end
  end

  assign w_level = w_wbin - w_rbin_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_ae <= 1'b1;
    end else begin
      r_ae <= (w_level <= AE_LVL);
    end
  end

  assign bus.ralmost_empty = r_ae;
`else
  assign bus.ralmost_empty = r_rempty;
`endif

  assign bus.raddr        = r_rbin[ADDR_SIZE-1:0];
  assign bus.rptr_gray    = r_rgray;
  assign bus.rdata        = r_rdata;
  assign bus.rvalid       = r_rvalid;
  assign bus.rempty       = r_rempty;
  assign bus.rd_underflow = r_underflow;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (ADDR_SIZE=3, DATA_SIZE=8, AE_LEVEL=2); honours RD_ALMOST_EMPTY_EN.
module tb_fifo_rd_ctrl;
  logic rclk;
  logic rrst;
  int   checks;
  int   errors;

  fifo_rd_ctrl_if #(.ADDR_SIZE(3), .DATA_SIZE(8)) bus();

  fifo_rd_ctrl #(.ADDR_SIZE(3), .DATA_SIZE(8), .AE_LEVEL(2)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  typedef struct {
    logic       rd_en;
    logic [3:0] wptr;
    logic [7:0] mem;
    logic [2:0] raddr;
    logic [3:0] gray;
    logic [7:0] rdata;
    logic       rvalid;
    logic       rempty;
    logic       uf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    step();
    rrst = 1'b0;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rempty"}, 32'(bus.rempty), 32'd1);
    check({tag, "_raddr"},  32'(bus.raddr), 32'd0);
    check({tag, "_gray"},   32'(bus.rptr_gray), 32'd0);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    check({tag, "_rdata"},  32'(bus.rdata), 32'd0);
    check({tag, "_uf"},     32'(bus.rd_underflow), 32'd0);
    check({tag, "_ae"},     32'(bus.ralmost_empty), 32'd1);
  endtask

  initial begin
    logic exp_ae;
    checks = 0;
    errors = 0;

    // single word arrives, gets read, then underflow attempts
    vecs[0] = '{1'b0, 4'b0001, 8'h00, 3'd0, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'b0001, 8'h00, 3'd0, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'b0001, 8'h00, 3'd0, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'b0001, 8'hA5, 3'd1, 4'b0001, 8'hA5, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'b0001, 8'h00, 3'd1, 4'b0001, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 4'b0001, 8'h33, 3'd1, 4'b0001, 8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 4'b0001, 8'h34, 3'd1, 4'b0001, 8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 4'b0001, 8'h35, 3'd1, 4'b0001, 8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 4'b0001, 8'h36, 3'd1, 4'b0001, 8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{1'b0, 4'b0001, 8'h00, 3'd1, 4'b0001, 8'hA5, 1'b0, 1'b1, 1'b1};

    // reset with busy inputs
    rrst = 1'b1;
    bus.rd_en = 1'b1;
    bus.wptr_gray = 4'b0101;
    bus.mem_rdata = 8'hFF;
    #2;
    check_reset_vals("rst_async");
    step();
    step();
    check_reset_vals("rst");
    bus.rd_en = 1'b0;
    bus.wptr_gray = 4'b0000;
    bus.mem_rdata = 8'h00;
    rrst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      bus.rd_en = vecs[v].rd_en;
      bus.wptr_gray = vecs[v].wptr;
      bus.mem_rdata = vecs[v].mem;
      step();
      check($sformatf("v%0d_raddr", v),  32'(bus.raddr), 32'(vecs[v].raddr));
      check($sformatf("v%0d_gray", v),   32'(bus.rptr_gray), 32'(vecs[v].gray));
      check($sformatf("v%0d_rdata", v),  32'(bus.rdata), 32'(vecs[v].rdata));
      check($sformatf("v%0d_rvalid", v), 32'(bus.rvalid), 32'(vecs[v].rvalid));
      check($sformatf("v%0d_rempty", v), 32'(bus.rempty), 32'(vecs[v].rempty));
      check($sformatf("v%0d_uf", v),     32'(bus.rd_underflow), 32'(vecs[v].uf));
`ifdef RD_ALMOST_EMPTY_EN
      exp_ae = 1'b1;
`else
      exp_ae = vecs[v].rempty;
`endif
      check($sformatf("v%0d_ae", v), 32'(bus.ralmost_empty), 32'(exp_ae));
    end

    // wrap: two passes of 8 reads each
    bus.rd_en = 1'b0;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      bus.wptr_gray = gray4(4'((pass + 1) * 8));
      step();
      step();
      check($sformatf("wrap%0d_empty_e2", pass), 32'(bus.rempty), 32'd1);
      step();
      check($sformatf("wrap%0d_empty_e3", pass), 32'(bus.rempty), 32'd0);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("wrap%0d_raddr%0d", pass, i), 32'(bus.raddr), 32'(i));
        bus.rd_en = 1'b1;
        bus.mem_rdata = 8'((pass * 16) + i);
        step();
        check($sformatf("wrap%0d_rvalid%0d", pass, i), 32'(bus.rvalid), 32'd1);
        check($sformatf("wrap%0d_rdata%0d", pass, i), 32'(bus.rdata), 32'((pass * 16) + i));
        check($sformatf("wrap%0d_gray%0d", pass, i), 32'(bus.rptr_gray),
              32'(gray4(4'((pass * 8) + i + 1))));
      end
      bus.rd_en = 1'b0;
      bus.mem_rdata = 8'hEE;
      step();
      check($sformatf("wrap%0d_end_raddr", pass), 32'(bus.raddr), 32'd0);
      check($sformatf("wrap%0d_end_gray", pass), 32'(bus.rptr_gray), (pass == 0) ? 32'hC : 32'h0);
      check($sformatf("wrap%0d_end_empty", pass), 32'(bus.rempty), 32'd1);
      check($sformatf("wrap%0d_end_rvalid", pass), 32'(bus.rvalid), 32'd0);
      check($sformatf("wrap%0d_end_uf", pass), 32'(bus.rd_underflow), 32'd0);
    end

    // almost empty: 5 words, level drops to AE_LEVEL after the 3rd read
    do_reset();
    bus.wptr_gray = 4'b0111;
    step();
    step();
    step();
    check("ae_fill_empty", 32'(bus.rempty), 32'd0);
    check("ae_fill_ae", 32'(bus.ralmost_empty), 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.rd_en = 1'b1;
      bus.mem_rdata = 8'h40 + 8'(i);
      step();
`ifdef RD_ALMOST_EMPTY_EN
      exp_ae = (i == 2);
`else
      exp_ae = 1'b0;
`endif
      check($sformatf("ae_read%0d_ae", i), 32'(bus.ralmost_empty), 32'(exp_ae));
      check($sformatf("ae_read%0d_empty", i), 32'(bus.rempty), 32'd0);
    end
    bus.rd_en = 1'b0;

    // mid-read reset: asynchronous pulse between edges
    do_reset();
    bus.wptr_gray = 4'b0110;
    step();
    step();
    step();
    bus.rd_en = 1'b1;
    bus.mem_rdata = 8'h5A;
    step();
    check("mid_pre_rvalid", 32'(bus.rvalid), 32'd1);
    check("mid_pre_raddr", 32'(bus.raddr), 32'd1);
    #2;
    rrst = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("mid_rst_rdata", 32'(bus.rdata), 32'd0);
    check("mid_rst_raddr", 32'(bus.raddr), 32'd0);
    check("mid_rst_gray", 32'(bus.rptr_gray), 32'd0);
    check("mid_rst_empty", 32'(bus.rempty), 32'd1);
    check("mid_rst_ae", 32'(bus.ralmost_empty), 32'd1);
    #1;
    rrst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mid_post%0d_rvalid", i), 32'(bus.rvalid), 32'd0);
      check($sformatf("mid_post%0d_raddr", i), 32'(bus.raddr), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
